// File: rtl/systolic_ctrl.sv
// Sequencer for one output-stationary pass of an N x N systolic array:
// clears accumulators, streams K SRAM beats with skewed lane valids, drains, then pulses done.
module systolic_ctrl #(
  parameter int DATAW      = 16,
  parameter int ARRAY_SIZE = 4,
  parameter int ADDR_W     = 16,
  parameter int KW         = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tpu_start,
  input  logic [ADDR_W-1:0]     data_base,
  input  logic [ADDR_W-1:0]     weight_base,
  input  logic [KW-1:0]         k_len,
  output logic                  rd_req,
  input  logic                  rd_gnt,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [ADDR_W-1:0]     weight_addr,
  output logic                  acc_clr,
  output logic                  systolic_en,
  output logic [ARRAY_SIZE-1:0] lane_valid,
  output logic                  busy,
  output logic                  done
);

  // state  | meaning
  // IDLE   | waiting for tpu_start
  // CLEAR  | one cycle of acc_clr
  // STREAM | requesting K beats from SRAM
  // DRAIN  | 2*N cycles letting the last partial products settle
  // DONE   | one-cycle done pulse
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  localparam int DW = $clog2(2 * ARRAY_SIZE);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * ARRAY_SIZE - 1);

  if (ARRAY_SIZE < 2 || DATAW < 1) begin : g_param_check
    $error("systolic_ctrl: ARRAY_SIZE must be >= 2 and DATAW >= 1");
  end

  state_t                  state;
  logic [ADDR_W-1:0]       d_base;
  logic [ADDR_W-1:0]       w_base;
  logic [KW-1:0]           k_q;
  logic [KW-1:0]           issued;
  logic [DW-1:0]           drain_cnt;
  logic [ARRAY_SIZE-1:0]   skew;
  logic                    beat;

  assign beat        = rd_req && rd_gnt;
  assign data_addr   = d_base + ADDR_W'(issued);
  assign weight_addr = w_base + ADDR_W'(issued);
  assign lane_valid  = skew;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      d_base      <= '0;
      w_base      <= '0;
      k_q         <= '0;
      issued      <= '0;
      drain_cnt   <= '0;
      rd_req      <= 1'b0;
      acc_clr     <= 1'b0;
      systolic_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      acc_clr <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (tpu_start) begin
            state   <= CLEAR;
            d_base  <= data_base;
            w_base  <= weight_base;
            k_q     <= k_len;
            issued  <= '0;
            busy    <= 1'b1;
            acc_clr <= 1'b1;
          end
        end
        CLEAR: begin
          if (k_q != '0) begin
            state       <= STREAM;
            rd_req      <= 1'b1;
            systolic_en <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        STREAM: begin
          if (beat) begin
            issued <= issued + KW'(1);
            if (issued == k_q - KW'(1)) begin
              state     <= DRAIN;
              rd_req    <= 1'b0;
              drain_cnt <= DRAIN_LAST;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state       <= DONE;
            systolic_en <= 1'b0;
            done        <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane 0 sees data one cycle after its grant (SRAM latency); later lanes are skewed by one each.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skew <= '0;
    end else if (state == STREAM || state == DRAIN) begin
      skew <= {skew[ARRAY_SIZE-2:0], beat};
    end else begin
      skew <= '0;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl: per-cycle tables of expected outputs built from a pass schedule model.
module tb_systolic_ctrl;
  localparam int N    = 4;
  localparam int AW   = 16;
  localparam int KW   = 8;
  localparam int MAXC = 135;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          tpu_start = 1'b0;
  logic [AW-1:0] data_base = '0;
  logic [AW-1:0] weight_base = '0;
  logic [KW-1:0] k_len = '0;
  logic          rd_gnt = 1'b1;
  logic          rd_req, acc_clr, systolic_en, busy, done;
  logic [AW-1:0] data_addr, weight_addr;
  logic [N-1:0]  lane_valid;

  systolic_ctrl #(.DATAW(16), .ARRAY_SIZE(N), .ADDR_W(AW), .KW(KW)) dut (
    .clk(clk), .rstn(rstn), .tpu_start(tpu_start), .data_base(data_base),
    .weight_base(weight_base), .k_len(k_len), .rd_req(rd_req), .rd_gnt(rd_gnt),
    .data_addr(data_addr), .weight_addr(weight_addr), .acc_clr(acc_clr),
    .systolic_en(systolic_en), .lane_valid(lane_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = -1;
  bit running = 1'b1;

  bit            start_tab [MAXC];
  bit            rst_tab   [MAXC];
  bit            gnt_tab   [MAXC];
  logic [AW-1:0] db_tab    [MAXC];
  logic [AW-1:0] wb_tab    [MAXC];
  logic [KW-1:0] k_tab     [MAXC];

  bit            e_req  [MAXC];
  bit            e_clr  [MAXC];
  bit            e_en   [MAXC];
  bit            e_busy [MAXC];
  bit            e_done [MAXC];
  logic [N-1:0]  e_lv   [MAXC];
  logic [AW-1:0] e_da   [MAXC];
  logic [AW-1:0] e_wa   [MAXC];

  task automatic chk(input string nm, input int c, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycle %0d got 0x%0h expected 0x%0h", nm, c, got, want);
    end
  endtask

  task automatic sched_start(input int s, input int k, input logic [AW-1:0] db, input logic [AW-1:0] wb);
    start_tab[s] = 1'b1;
    k_tab[s]     = KW'(k);
    db_tab[s]    = db;
    wb_tab[s]    = wb;
  endtask

  // Schedule of one pass started in cycle s; nothing is recorded from cycle 'stop' on. Returns done cycle.
  function automatic int plan_pass(input int s, input int k, input logic [AW-1:0] db,
                                   input logic [AW-1:0] wb, input int stop);
    bit g_at [MAXC];
    int c, g, d0, dn;
    for (int t = 0; t < MAXC; t++) g_at[t] = 1'b0;
    if (s + 1 < stop) e_clr[s+1] = 1'b1;
    if (k == 0) begin
      dn = s + 2;
    end else begin
      c = s + 2;
      g = 0;
      while (g < k) begin
        if (c < stop) begin
          e_req[c] = 1'b1;
          e_en[c]  = 1'b1;
          e_da[c]  = db + AW'(g);
          e_wa[c]  = wb + AW'(g);
        end
        if (gnt_tab[c]) begin
          g_at[c] = 1'b1;
          g++;
        end
        c++;
      end
      d0 = c;
      for (int j = 0; j < 2 * N; j++) if (d0 + j < stop) e_en[d0+j] = 1'b1;
      dn = d0 + 2 * N;
      for (int t = s + 2; t < dn; t++)
        for (int i = 0; i < N; i++)
          if (t < stop && t - 1 - i >= s + 2 && g_at[t-1-i]) e_lv[t][i] = 1'b1;
    end
    for (int t = s + 1; t <= dn; t++) if (t < stop) e_busy[t] = 1'b1;
    if (dn < stop) e_done[dn] = 1'b1;
    return dn;
  endfunction

  always @(negedge clk) begin
    if (running && cyc >= 0 && cyc < MAXC) begin
      chk("rd_req", cyc, rd_req, e_req[cyc]);
      chk("acc_clr", cyc, acc_clr, e_clr[cyc]);
      chk("systolic_en", cyc, systolic_en, e_en[cyc]);
      chk("busy", cyc, busy, e_busy[cyc]);
      chk("done", cyc, done, e_done[cyc]);
      chk("lane_valid", cyc, lane_valid, e_lv[cyc]);
      if (e_req[cyc]) begin
        chk("data_addr", cyc, data_addr, e_da[cyc]);
        chk("weight_addr", cyc, weight_addr, e_wa[cyc]);
      end else if (rst_tab[cyc]) begin
        chk("data_addr_rst", cyc, data_addr, 0);
        chk("weight_addr_rst", cyc, weight_addr, 0);
      end
    end
  end

  initial begin
    int dn;
    for (int t = 0; t < MAXC; t++) begin
      start_tab[t] = 0; rst_tab[t] = 0; gnt_tab[t] = 1;
      db_tab[t] = 16'hAAAA; wb_tab[t] = 16'h5555; k_tab[t] = 8'hFF;
      e_req[t] = 0; e_clr[t] = 0; e_en[t] = 0; e_busy[t] = 0; e_done[t] = 0;
      e_lv[t] = '0; e_da[t] = '0; e_wa[t] = '0;
    end
    for (int t = 0; t < 3; t++) rst_tab[t] = 1;
    rst_tab[107] = 1;
    rst_tab[108] = 1;
    gnt_tab[28]  = 0;

    // A: basic K=3 pass
    sched_start(4, 3, 16'h0010, 16'h0100);
    dn = plan_pass(4, 3, 16'h0010, 16'h0100, MAXC);
    chk("pin_A_done", 4, dn, 17);
    chk("pin_A_clr", 5, e_clr[5], 1);
    chk("pin_A_addr", 6, {e_da[6], e_da[7], e_da[8]}, 48'h0010_0011_0012);
    chk("pin_A_lane0", 7, {e_lv[6][0], e_lv[7][0], e_lv[9][0], e_lv[10][0]}, 4'b0110);
    chk("pin_A_lane3", 10, {e_lv[9][3], e_lv[10][3], e_lv[12][3], e_lv[13][3]}, 4'b0110);
    // B: one grant stall in the second stream cycle
    sched_start(25, 3, 16'h0010, 16'h0100);
    dn = plan_pass(25, 3, 16'h0010, 16'h0100, MAXC);
    chk("pin_B_done", 25, dn, 39);
    chk("pin_B_hold", 28, {e_da[28], e_da[29]}, 32'h0011_0011);
    chk("pin_B_lane0", 28, {e_lv[28][0], e_lv[29][0], e_lv[30][0], e_lv[31][0]}, 4'b1011);
    // C: K=0
    sched_start(45, 0, 16'h0030, 16'h0300);
    dn = plan_pass(45, 0, 16'h0030, 16'h0300, MAXC);
    chk("pin_C_done", 45, dn, 47);
    // D: address wrap
    sched_start(52, 4, 16'hFFFE, 16'h0200);
    dn = plan_pass(52, 4, 16'hFFFE, 16'h0200, MAXC);
    chk("pin_D_done", 52, dn, 66);
    chk("pin_D_addr", 54, {e_da[54], e_da[55], e_da[56], e_da[57]}, 64'hFFFE_FFFF_0000_0001);
    // E: starts during STREAM and DONE are ignored; start right after DONE runs
    sched_start(70, 2, 16'h0040, 16'h0400);
    dn = plan_pass(70, 2, 16'h0040, 16'h0400, MAXC);
    chk("pin_E_done", 70, dn, 82);
    sched_start(73, 5, 16'h0700, 16'h0800);
    sched_start(82, 5, 16'h0700, 16'h0800);
    sched_start(83, 1, 16'h0050, 16'h0500);
    dn = plan_pass(83, 1, 16'h0050, 16'h0500, MAXC);
    chk("pin_E2_done", 83, dn, 94);
    // F: reset during DRAIN abandons the pass; next start is a clean pass
    sched_start(100, 3, 16'h0060, 16'h0600);
    dn = plan_pass(100, 3, 16'h0060, 16'h0600, 107);
    chk("pin_F_drain", 106, {e_en[106], e_busy[106], e_en[107], e_busy[107]}, 4'b1100);
    sched_start(112, 3, 16'h0020, 16'h0200);
    dn = plan_pass(112, 3, 16'h0020, 16'h0200, MAXC);
    chk("pin_F2_done", 112, dn, 125);

    for (int c = 0; c < MAXC; c++) begin
      @(posedge clk);
      cyc = c;
      #1;
      rstn        = !rst_tab[c];
      tpu_start   = start_tab[c];
      rd_gnt      = gnt_tab[c];
      data_base   = db_tab[c];
      weight_base = wb_tab[c];
      k_len       = k_tab[c];
    end
    @(posedge clk);
    running = 1'b0;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
